// File: rtl/work_dispatcher.sv
// ---------------------------------------------------------------------------
// work_dispatcher
//
// Frame-level scheduler for the worker array. Accepts jobs from an upstream
// source while a frame is open, issues each one to a free worker with a
// one-cycle start pulse, tracks which workers are busy, and pulses
// frame_done once the last job has gone out and every worker is idle again.
//
// Optional build macro:
//   ROUND_ROBIN_EN  defined   -> worker search starts one past the last
//                                worker picked, wrapping around
//                   undefined -> fixed priority, lowest free index wins
//
// Ports:
//   clk           system clock
//   n_rst         asynchronous active-low reset (workers share it)
//   frame_start   pulse, opens a new frame (ignored unless idle)
//   job_valid     upstream job available
//   job_data      job payload
//   job_last      marks job_data as the final job of the frame
//   job_ready     dispatcher takes the job this cycle
//   worker_done   per-worker level, 1 = idle/finished
//   worker_start  one-hot, one-cycle start pulse
//   worker_job    payload for the worker pulsed, held until next issue
//   worker_sel    index of worker pulsed, NUM_WORKERS when none
//   busy_count    number of workers currently marked busy
//   frame_done    one-cycle pulse when the frame is complete
//
// FSM states:
//   state      | meaning
//   S_IDLE     | no frame open, waiting for frame_start
//   S_DISPATCH | frame open, issuing jobs to free workers
//   S_DRAIN    | last job issued, waiting for all workers to finish
//   S_DONE     | frame complete, frame_done asserted for one cycle
// ---------------------------------------------------------------------------
module work_dispatcher #(
    parameter int NUM_WORKERS = 16,
    parameter int JOB_W       = 32
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          frame_start,
    input  logic                          job_valid,
    input  logic [JOB_W-1:0]              job_data,
    input  logic                          job_last,
    output logic                          job_ready,
    input  logic [NUM_WORKERS-1:0]        worker_done,
    output logic [NUM_WORKERS-1:0]        worker_start,
    output logic [JOB_W-1:0]              worker_job,
    output logic [$clog2(NUM_WORKERS):0]  worker_sel,
    output logic [$clog2(NUM_WORKERS):0]  busy_count,
    output logic                          frame_done
);

    localparam int              IDX_W    = $clog2(NUM_WORKERS);
    localparam logic [IDX_W:0]  SEL_NONE = (IDX_W + 1)'(NUM_WORKERS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_DRAIN    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [NUM_WORKERS-1:0] r_busy;
    logic [NUM_WORKERS-1:0] r_done_q;
    logic [NUM_WORKERS-1:0] r_start;
    logic [JOB_W-1:0]       r_job;
    logic [IDX_W:0]         r_sel;
    logic [IDX_W:0]         r_busy_cnt;

    logic [NUM_WORKERS-1:0] w_free;
    logic [NUM_WORKERS-1:0] w_rise;
    logic [NUM_WORKERS-1:0] w_onehot;
    logic [NUM_WORKERS-1:0] w_busy_nxt;
    logic [IDX_W:0]         w_busy_cnt_nxt;
    logic [IDX_W:0]         w_idx;
    logic [IDX_W-1:0]       w_k;
    logic                   w_found;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_frame_done;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0]       r_last_idx;
`endif

    // A worker is free only when it reports idle and we have not handed it
    // a job it has yet to acknowledge by dropping done.
    assign w_free   = worker_done & ~r_busy;
    assign w_rise   = worker_done & ~r_done_q;
    assign w_ready  = (r_state == S_DISPATCH) && (|w_free);
    assign w_accept = job_valid && w_ready;

    // ------------------------------------------------------------------
    // Worker selection
    // ------------------------------------------------------------------
    always_comb begin
        w_found  = 1'b0;
        w_idx    = SEL_NONE;
        w_onehot = '0;
        w_k      = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
`ifdef ROUND_ROBIN_EN
            w_k = IDX_W'((int'(r_last_idx) + 1 + i) % NUM_WORKERS);
`else
            w_k = IDX_W'(i);
`endif
            if (!w_found && w_free[w_k]) begin
                w_found       = 1'b1;
                w_idx         = {1'b0, w_k};
                w_onehot[w_k] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy tracking. Set and clear never collide on one worker: a set
    // needs the worker free (done high, not busy), a clear needs a rising
    // done edge, which only happens while it is busy.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt = r_busy & ~w_rise;
        if (w_accept) begin
            w_busy_nxt = w_busy_nxt | w_onehot;
        end
    end

    always_comb begin
        w_busy_cnt_nxt = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            w_busy_cnt_nxt = w_busy_cnt_nxt + {{IDX_W{1'b0}}, w_busy_nxt[i]};
        end
    end

    // done_q resets to all ones so workers sitting idle out of reset are
    // not mistaken for a finish event.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_busy     <= '0;
            r_done_q   <= '1;
            r_start    <= '0;
            r_job      <= '0;
            r_sel      <= SEL_NONE;
            r_busy_cnt <= '0;
        end else begin
            r_done_q   <= worker_done;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
            if (w_accept) begin
                r_start <= w_onehot;
                r_job   <= job_data;
                r_sel   <= w_idx;
            end else begin
                r_start <= '0;
                r_sel   <= SEL_NONE;
            end
        end
    end

`ifdef ROUND_ROBIN_EN
    // Starting at NUM_WORKERS-1 makes the first search begin at worker 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_last_idx <= IDX_W'(NUM_WORKERS - 1);
        end else if (w_accept) begin
            r_last_idx <= w_idx[IDX_W-1:0];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_nxt = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (w_accept && job_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The start pulse of the last job is still in flight on the
                // first drain cycle; wait for it as well as the busy mask.
                if ((r_busy == '0) && (r_start == '0)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_frame_done = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign job_ready    = w_ready;
    assign worker_start = r_start;
    assign worker_job   = r_job;
    assign worker_sel   = r_sel;
    assign busy_count   = r_busy_cnt;
    assign frame_done   = w_frame_done;

endmodule
